// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encoding, default latencies and FSM state encoding.
// Imported by the decoder, the hazard unit and the MDU itself.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU operand/result bundle between the pipeline (master) and the MDU (slave).
interface e_mdu_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, mdu_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: 64-bit {hi, lo} result for mult/div ops plus a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        is_signed_div;

  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps naturally to 0x80000000.
  assign is_signed_div = (op_i == OP_DIV);
  assign mag_a = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign mag_b = b_i[31] ? (~b_i + 32'd1) : b_i;
  assign div_a = is_signed_div ? mag_a : a_i;
  assign div_b = (b_i == 32'd0) ? 32'd1 : (is_signed_div ? mag_b : b_i);
  assign quo   = div_a / div_b;
  assign rem   = div_a % div_b;

  always_comb begin
    result_o   = 64'd0;
    div_zero_o = 1'b0;
    case (op_i)
      OP_MULT:  result_o = prod_s;
      OP_MULTU: result_o = prod_u;
      OP_DIV: begin
        div_zero_o = (b_i == 32'd0);
        result_o[31:0]  = (a_i[31] ^ b_i[31]) ? (~quo + 32'd1) : quo;
        result_o[63:32] = a_i[31] ? (~rem + 32'd1) : rem;
      end
      OP_DIVU: begin
        div_zero_o = (b_i == 32'd0);
        result_o   = {rem, quo};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO owner with fixed-latency busy window for long ops.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  mdu
);

  // state   | meaning
  // IDLE    | no long op in flight; MTHI/MTLO and long-op starts accepted
  // RUN     | long op counting down; result held in pend_* until count reaches 1

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pend_hi_q;
  logic [31:0]      pend_lo_q;
  logic             pend_dz_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;

  logic [63:0]      calc_res;
  logic             calc_dz;
  logic             commit_d;
  logic             accept_d;

  mdu_calc u_calc (
    .op_i       (mdu.mdu_op),
    .a_i        (mdu.src_a),
    .b_i        (mdu.src_b),
    .result_o   (calc_res),
    .div_zero_o (calc_dz)
  );

  // The commit edge also accepts a new op, giving zero-bubble back-to-back issue.
  assign commit_d = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));
  assign accept_d = mdu.start && ((state_q == ST_IDLE) || commit_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (commit_d) begin
        if (!pend_dz_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (accept_d) begin
        if (is_long_op(mdu.mdu_op)) begin
          pend_hi_q <= calc_res[63:32];
          pend_lo_q <= calc_res[31:0];
          pend_dz_q <= calc_dz;
          cnt_q     <= ((mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
          state_q   <= ST_RUN;
          busy_q    <= 1'b1;
        end else if (mdu.mdu_op == OP_MTHI) begin
          hi_q <= mdu.src_a;
        end else if (mdu.mdu_op == OP_MTLO) begin
          lo_q <= mdu.src_a;
        end
      end
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus random ops against an arithmetic HI/LO model.
module tb_e_mdu;

  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  e_mdu_if mif ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latency(input logic [2:0] op);
    if (op == MULT || op == MULTU) return 5;
    if (op == DIV || op == DIVU) return 10;
    return 0;
  endfunction

  // Architectural effect of one op on the expected HI/LO pair.
  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:  begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      MULTU: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      DIV:   if (b != 0) begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
      DIVU:  if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      MTHI:  exp_hi = a;
      MTLO:  exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issues one op at a negedge and checks the busy window and final HI/LO; returns at a negedge.
  task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    logic [31:0] old_hi, old_lo;
    n = latency(op);
    old_hi = exp_hi;
    old_lo = exp_lo;
    mif.start = 1'b1; mif.mdu_op = op; mif.src_a = a; mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0; mif.mdu_op = NONE; mif.src_a = $urandom; mif.src_b = $urandom;
    model_apply(op, a, b);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (mif.busy !== 1'b1 || mif.hi !== old_hi || mif.lo !== old_lo) begin
        n_fail++;
        $display("FAIL %s busy-cycle %0d: got busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                 name, i, mif.busy, mif.hi, mif.lo, old_hi, old_lo);
      end
      @(negedge clk);
    end
    n_checks++;
    if (mif.busy !== 1'b0 || mif.hi !== exp_hi || mif.lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s result: got busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
               name, mif.busy, mif.hi, mif.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mif.start = 1'b0; mif.mdu_op = NONE; mif.src_a = '0; mif.src_b = '0;
    exp_hi = '0; exp_lo = '0;
    #12;
    n_checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b hi=%h lo=%h, want 0/0/0", mif.busy, mif.hi, mif.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    exec_op(MULT, 32'hFFFFFFFD, 32'h00000007, "mult_neg3x7");
    n_checks++;
    if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFEB) begin
      n_fail++;
      $display("FAIL mult_const: got hi=%h lo=%h, want FFFFFFFF FFFFFFEB", mif.hi, mif.lo);
    end
    exec_op(MULTU, 32'hFFFFFFFF, 32'h00000002, "multu_max_x2");
    n_checks++;
    if (mif.hi !== 32'h00000001 || mif.lo !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL multu_const: got hi=%h lo=%h, want 00000001 FFFFFFFE", mif.hi, mif.lo);
    end
  endtask

  task automatic test_div();
    exec_op(DIV, 32'hFFFFFFF9, 32'h00000002, "div_neg7_2");
    n_checks++;
    if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL div_const: got hi=%h lo=%h, want FFFFFFFF FFFFFFFD", mif.hi, mif.lo);
    end
    exec_op(MTHI, 32'h11, 32'h0, "preset_hi");
    exec_op(MTLO, 32'h22, 32'h0, "preset_lo");
    exec_op(DIVU, 32'h7, 32'h0, "divu_by_zero");
    n_checks++;
    if (mif.hi !== 32'h11 || mif.lo !== 32'h22) begin
      n_fail++;
      $display("FAIL divu_zero_keep: got hi=%h lo=%h, want 00000011 00000022", mif.hi, mif.lo);
    end
    exec_op(DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    n_checks++;
    if (mif.hi !== 32'h0 || mif.lo !== 32'h80000000) begin
      n_fail++;
      $display("FAIL div_overflow_const: got hi=%h lo=%h, want 00000000 80000000", mif.hi, mif.lo);
    end
    exec_op(DIV, 32'h5, 32'h0, "div_by_zero_signed");
  endtask

  task automatic test_mthi();
    exec_op(MTHI, 32'hDEADBEEF, 32'h0, "mthi");
    n_checks++;
    if (mif.hi !== 32'hDEADBEEF || mif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_const: got hi=%h busy=%b, want DEADBEEF 0", mif.hi, mif.busy);
    end
  endtask

  // DIV then MULT issued on the DIV commit edge; mid-run MTLO/DIV starts must be dropped.
  task automatic test_back_to_back();
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi; old_lo = exp_lo;
    mif.start = 1'b1; mif.mdu_op = DIV; mif.src_a = 32'd100; mif.src_b = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    model_apply(DIV, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (mif.busy !== 1'b1 || mif.hi !== old_hi || mif.lo !== old_lo) begin
        n_fail++;
        $display("FAIL b2b_div busy-cycle %0d: got busy=%b hi=%h lo=%h, want 1 %h %h",
                 i, mif.busy, mif.hi, mif.lo, old_hi, old_lo);
      end
      if (i == 3) begin mif.start = 1'b1; mif.mdu_op = MTLO; mif.src_a = 32'h5555AAAA; end
      else if (i == 4) begin mif.start = 1'b1; mif.mdu_op = DIV; mif.src_a = 32'd9; mif.src_b = 32'd3; end
      else if (i == 9) begin mif.start = 1'b1; mif.mdu_op = MULT; mif.src_a = 32'd2; mif.src_b = 32'd3; end
      else mif.start = 1'b0;
      @(negedge clk);
    end
    mif.start = 1'b0; mif.mdu_op = NONE;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (mif.busy !== 1'b1 || mif.hi !== exp_hi || mif.lo !== exp_lo) begin
        n_fail++;
        $display("FAIL b2b_mult busy-cycle %0d: got busy=%b hi=%h lo=%h, want 1 %h %h",
                 j, mif.busy, mif.hi, mif.lo, exp_hi, exp_lo);
      end
      @(negedge clk);
    end
    model_apply(MULT, 32'd2, 32'd3);
    n_checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd6) begin
      n_fail++;
      $display("FAIL b2b_result: got busy=%b hi=%h lo=%h, want 0 00000000 00000006",
               mif.busy, mif.hi, mif.lo);
    end
  endtask

  task automatic test_reset_mid();
    exec_op(MTHI, 32'hA5A5A5A5, 32'h0, "pre_reset_hi");
    mif.start = 1'b1; mif.mdu_op = MULT; mif.src_a = 32'd1000; mif.src_b = 32'd1000;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h, want 0/0/0", mif.busy, mif.hi, mif.lo);
    end
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: got busy=%b hi=%h lo=%h, want 0/0/0",
                 i, mif.busy, mif.hi, mif.lo);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exec_op(op, a, b, "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
